mem_copy_engine: RTL

Block-transfer sequencer directly upstream of the 256x8 single-port memory. It drives that memory's addr/data_in/rd/wr pins and consumes its combinational data_out. On a start pulse it copies a byte range from source to destination, or fills the destination range with a constant. Only one memory access happens per cycle, and rd and wr are never asserted together.

---
 rtl/mem_copy_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy / fill sequencer for a 256x8 single-port memory.
// Each job runs one memory access per cycle. A copy alternates READ then WRITE
// for each byte, and a fill streams WRITEs. The memory strobes are never both high.
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bytes_done
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_mode;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_len;
  logic [DATA_W-1:0] r_fill;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] r_bytes_done;

  // Memory-side outputs are registered one cycle ahead, so they always match
  // the state the machine is currently in. In copy mode r_mem_data_in also
  // serves as the byte buffer filled by the preceding READ.
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data_in;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W-1:0] w_index_nxt;
  logic              w_last;
  logic [ADDR_W-1:0] w_wr_addr_cur;
  logic [ADDR_W-1:0] w_rd_addr_nxt;
  logic [ADDR_W-1:0] w_wr_addr_nxt;

  // Address arithmetic wraps naturally at ADDR_W bits
  assign w_index_nxt   = r_index + ONE;
  assign w_last        = (r_index == (r_len - ONE));
  assign w_wr_addr_cur = r_dst + r_index;
  assign w_rd_addr_nxt = r_src + w_index_nxt;
  assign w_wr_addr_nxt = r_dst + w_index_nxt;

  // Sequencer: state, captured job parameters, progress counters and strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_mode        <= 1'b0;
      r_src         <= '0;
      r_dst         <= '0;
      r_len         <= '0;
      r_fill        <= '0;
      r_index       <= '0;
      r_bytes_done  <= '0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_mem_rd      <= 1'b0;
          r_mem_wr      <= 1'b0;
          r_busy        <= 1'b0;
          r_done        <= 1'b0;
          r_mem_addr    <= '0;
          r_mem_data_in <= '0;
          if (start) begin
            r_mode       <= mode;
            r_src        <= src_addr;
            r_dst        <= dst_addr;
            r_len        <= length;
            r_fill       <= fill_value;
            r_index      <= '0;
            r_bytes_done <= '0;
            if (length == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (!mode) begin
              r_state    <= ST_READ;
              r_busy     <= 1'b1;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= src_addr;
            end else begin
              r_state       <= ST_WRITE;
              r_busy        <= 1'b1;
              r_mem_wr      <= 1'b1;
              r_mem_addr    <= dst_addr;
              r_mem_data_in <= fill_value;
            end
          end
        end

        ST_READ: begin
          // Latch the source byte straight into the write-data register
          r_state       <= ST_WRITE;
          r_mem_rd      <= 1'b0;
          r_mem_wr      <= 1'b1;
          r_mem_addr    <= w_wr_addr_cur;
          r_mem_data_in <= mem_data_out;
        end

        ST_WRITE: begin
          r_index      <= w_index_nxt;
          r_bytes_done <= r_bytes_done + ONE;
          if (w_last) begin
            r_state       <= ST_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
          end else if (!r_mode) begin
            r_state       <= ST_READ;
            r_mem_rd      <= 1'b1;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= w_rd_addr_nxt;
            r_mem_data_in <= '0;
          end else begin
            r_state       <= ST_WRITE;
            r_mem_addr    <= w_wr_addr_nxt;
            r_mem_data_in <= r_fill;
          end
        end

        ST_DONE: begin
          // Single-cycle completion pulse; start is not sampled here
          r_state  <= ST_IDLE;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // A write still pending in the cycle reset arrives must not reach the array
  assign mem_wr      = r_mem_wr & ~reset;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_data_in;
  assign busy        = r_busy;
  assign done        = r_done;
  assign bytes_done  = r_bytes_done;

endmodule
